// File: rtl/wb_daq_sram_arbiter.sv
// Round-robin arbiter that moves one DAQ channel word at a time into a shared
// single-port SRAM, each channel writing its own circular address region.
//
// state   | meaning
// IDLE    | waiting for an enabled request
// GRANT   | grant pulse to the selected channel
// CAPTURE | latch channel data and {channel, pointer} address
// WRITE   | write strobe held until sram_ack
// DONE    | data_done pulse, then back to IDLE
module wb_daq_sram_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                               wb_clk,
    input  logic                               wb_rst_n,
    input  logic                               master_enable,
    input  logic                               clear_ptrs,
    input  logic [NUM_CHANNELS-1:0]            start_sram,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] channel_data,
    output logic [NUM_CHANNELS-1:0]            grant,
    output logic [NUM_CHANNELS-1:0]            data_done,
    output logic                               sram_we,
    output logic [ADDR_WIDTH-1:0]              sram_addr,
    output logic [DATA_WIDTH-1:0]              sram_wdata,
    input  logic                               sram_ack,
    output logic [NUM_CHANNELS-1:0]            wrapped,
    output logic                               busy
);

    localparam int CH_BITS  = $clog2(NUM_CHANNELS);
    localparam int PTR_BITS = ADDR_WIDTH - CH_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_CAPTURE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [CH_BITS-1:0]       cur_ch_q, cur_ch_d;
    logic [CH_BITS-1:0]       last_ch_q, last_ch_d;
    logic [PTR_BITS-1:0]      ptr_q [NUM_CHANNELS];
    logic [PTR_BITS-1:0]      ptr_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  wrapped_q, wrapped_d;
    logic [NUM_CHANNELS-1:0]  grant_q, grant_d;
    logic [NUM_CHANNELS-1:0]  done_q, done_d;
    logic                     we_q, we_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     busy_q, busy_d;

    logic [CH_BITS-1:0]       rr_idx, rr_cand;
    logic                     rr_found;

    // Search starts one past the last served channel; the final candidate is last_ch itself.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = last_ch_q;
        rr_cand  = last_ch_q;
        for (int i = 1; i <= NUM_CHANNELS; i++) begin
            rr_cand = last_ch_q + CH_BITS'(i);
            if (!rr_found && start_sram[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_ch_d  = cur_ch_q;
        last_ch_d = last_ch_q;
        wrapped_d = wrapped_q;
        grant_d   = '0;
        done_d    = '0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            ptr_d[i] = ptr_q[i];
        end

        case (state_q)
            S_IDLE: begin
                if (master_enable && rr_found) begin
                    state_d          = S_GRANT;
                    cur_ch_d         = rr_idx;
                    grant_d[rr_idx]  = 1'b1;
                end
            end
            S_GRANT: state_d = S_CAPTURE;
            S_CAPTURE: begin
                wdata_d = channel_data[int'(cur_ch_q)*DATA_WIDTH +: DATA_WIDTH];
                addr_d  = {cur_ch_q, ptr_q[cur_ch_q]};
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (sram_ack) begin
                    if (ptr_q[cur_ch_q] == '1) begin
                        ptr_d[cur_ch_q]     = '0;
                        wrapped_d[cur_ch_q] = 1'b1;
                    end else begin
                        ptr_d[cur_ch_q] = ptr_q[cur_ch_q] + 1'b1;
                    end
                    last_ch_d          = cur_ch_q;
                    done_d[cur_ch_q]   = 1'b1;
                    state_d            = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Clear overrides a coincident advance; the write already used the old address.
        if (clear_ptrs) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                ptr_d[i] = '0;
            end
            wrapped_d = '0;
        end

        we_d   = (state_d == S_WRITE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= S_IDLE;
            cur_ch_q  <= '0;
            last_ch_q <= CH_BITS'(NUM_CHANNELS - 1);
            wrapped_q <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            last_ch_q <= last_ch_d;
            wrapped_q <= wrapped_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
        end
    end

    assign grant      = grant_q;
    assign data_done  = done_q;
    assign sram_we    = we_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign wrapped    = wrapped_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_wb_daq_sram_arbiter.sv
// Directed bench for wb_daq_sram_arbiter: timing, round-robin order, ack stall,
// pointer wrap, clear-on-ack, disable and reset during a transfer.
module tb_wb_daq_sram_arbiter;

    logic         wb_clk;
    logic         wb_rst_n;
    logic         master_enable;
    logic         clear_ptrs;
    logic [3:0]   start_sram;
    logic [127:0] channel_data;
    logic [3:0]   grant;
    logic [3:0]   data_done;
    logic         sram_we;
    logic [9:0]   sram_addr;
    logic [31:0]  sram_wdata;
    logic         sram_ack;
    logic [3:0]   wrapped;
    logic         busy;

    int total = 0;
    int bad   = 0;

    wb_daq_sram_arbiter #(.NUM_CHANNELS(4), .ADDR_WIDTH(10), .DATA_WIDTH(32)) dut (
        .wb_clk        (wb_clk),
        .wb_rst_n      (wb_rst_n),
        .master_enable (master_enable),
        .clear_ptrs    (clear_ptrs),
        .start_sram    (start_sram),
        .channel_data  (channel_data),
        .grant         (grant),
        .data_done     (data_done),
        .sram_we       (sram_we),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_ack      (sram_ack),
        .wrapped       (wrapped),
        .busy          (busy)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        wb_rst_n = 1'b0;
        @(negedge wb_clk);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
    endtask

    // One transfer with ack already high; caller has set the requests.
    task automatic xfer(input int ch, input logic [9:0] ea, input logic [31:0] ed, input bit drop);
        int n;
        n = 0;
        while (grant == 4'b0 && n < 20) begin @(negedge wb_clk); n++; end
        chk("xfer_grant", grant, 4'b0001 << ch);
        n = 0;
        while (!sram_we && n < 10) begin @(negedge wb_clk); n++; end
        chk("xfer_addr", sram_addr, ea);
        chk("xfer_wdata", sram_wdata, ed);
        n = 0;
        while (data_done == 4'b0 && n < 20) begin @(negedge wb_clk); n++; end
        chk("xfer_done", data_done, 4'b0001 << ch);
        if (drop) start_sram[ch] = 1'b0;
        @(negedge wb_clk);
    endtask

    initial begin
        int n;
        int gcount;
        wb_rst_n      = 1'b0;
        master_enable = 1'b0;
        clear_ptrs    = 1'b0;
        start_sram    = 4'b0;
        sram_ack      = 1'b0;
        for (int i = 0; i < 4; i++) channel_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        channel_data[31:0] = 32'hA5A5_0001;
        @(negedge wb_clk);
        @(negedge wb_clk);

        // reset values while held in reset
        chk("rst_grant", grant, 4'b0);
        chk("rst_done", data_done, 4'b0);
        chk("rst_we", sram_we, 1'b0);
        chk("rst_addr", sram_addr, 10'h0);
        chk("rst_wdata", sram_wdata, 32'h0);
        chk("rst_wrapped", wrapped, 4'b0);
        chk("rst_busy", busy, 1'b0);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);

        // single channel, immediate ack, cycle-exact
        master_enable = 1'b1;
        sram_ack      = 1'b1;
        start_sram    = 4'b0001;
        @(negedge wb_clk);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_busy", busy, 1'b1);
        @(negedge wb_clk);
        chk("t1_grant_off", grant, 4'b0);
        chk("t1_we_capture", sram_we, 1'b0);
        @(negedge wb_clk);
        chk("t1_we", sram_we, 1'b1);
        chk("t1_addr", sram_addr, 10'h000);
        chk("t1_wdata", sram_wdata, 32'hA5A5_0001);
        @(negedge wb_clk);
        chk("t1_done", data_done, 4'b0001);
        chk("t1_we_off", sram_we, 1'b0);
        start_sram = 4'b0;
        @(negedge wb_clk);
        chk("t1_done_off", data_done, 4'b0);
        chk("t1_idle", busy, 1'b0);
        start_sram = 4'b0001;
        xfer(0, 10'h001, 32'hA5A5_0001, 1'b1);

        // all four requesting continuously from reset
        do_reset();
        for (int i = 0; i < 4; i++) channel_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        start_sram = 4'b1111;
        xfer(0, 10'h000, 32'hC0DE_0000, 1'b0);
        xfer(1, 10'h100, 32'hC0DE_0001, 1'b0);
        xfer(2, 10'h200, 32'hC0DE_0002, 1'b0);
        xfer(3, 10'h300, 32'hC0DE_0003, 1'b0);
        xfer(0, 10'h001, 32'hC0DE_0000, 1'b0);
        start_sram = 4'b0;
        @(negedge wb_clk);
        @(negedge wb_clk);

        // ack stall: ack low for 7 write cycles, high on the 8th
        sram_ack   = 1'b0;
        start_sram = 4'b0010;
        n = 0;
        while (!sram_we && n < 20) begin @(negedge wb_clk); n++; end
        for (int k = 0; k < 8; k++) begin
            chk("stall_we", sram_we, 1'b1);
            chk("stall_addr", sram_addr, 10'h101);
            chk("stall_wdata", sram_wdata, 32'hC0DE_0001);
            chk("stall_no_grant", grant, 4'b0);
            chk("stall_no_done", data_done, 4'b0);
            if (k == 7) sram_ack = 1'b1;
            @(negedge wb_clk);
        end
        chk("stall_done", data_done, 4'b0010);
        chk("stall_we_off", sram_we, 1'b0);
        start_sram = 4'b0;
        @(negedge wb_clk);
        chk("stall_done_off", data_done, 4'b0);

        // wrap of channel 2 after 256 writes
        do_reset();
        start_sram = 4'b0100;
        for (int i = 0; i < 256; i++) begin
            if (i == 255) chk("wrap_before", wrapped, 4'b0000);
            xfer(2, 10'h200 + 10'(i), 32'hC0DE_0002, 1'b0);
        end
        chk("wrap_set", wrapped, 4'b0100);
        xfer(2, 10'h200, 32'hC0DE_0002, 1'b1);
        @(negedge wb_clk);

        // clear coinciding with ack, ptr1 = 5
        start_sram = 4'b0010;
        for (int i = 0; i < 5; i++) xfer(1, 10'h100 + 10'(i), 32'hC0DE_0001, 1'b0);
        start_sram = 4'b0;
        @(negedge wb_clk);
        sram_ack   = 1'b0;
        start_sram = 4'b0010;
        n = 0;
        while (!sram_we && n < 20) begin @(negedge wb_clk); n++; end
        chk("clr_addr", sram_addr, 10'h105);
        sram_ack   = 1'b1;
        clear_ptrs = 1'b1;
        @(negedge wb_clk);
        clear_ptrs = 1'b0;
        chk("clr_done", data_done, 4'b0010);
        chk("clr_wrapped", wrapped, 4'b0000);
        start_sram = 4'b0;
        @(negedge wb_clk);
        start_sram = 4'b0010;
        xfer(1, 10'h100, 32'hC0DE_0001, 1'b1);
        start_sram = 4'b0100;
        xfer(2, 10'h200, 32'hC0DE_0002, 1'b1);

        // disable during WRITE: transfer finishes, nothing new granted
        sram_ack   = 1'b0;
        start_sram = 4'b1111;
        n = 0;
        while (!sram_we && n < 20) begin @(negedge wb_clk); n++; end
        chk("dis_addr", sram_addr, 10'h300);
        master_enable = 1'b0;
        sram_ack      = 1'b1;
        @(negedge wb_clk);
        chk("dis_done", data_done, 4'b1000);
        gcount = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge wb_clk);
            if (grant != 4'b0) gcount++;
        end
        chk("dis_no_grant", gcount, 0);
        chk("dis_idle", busy, 1'b0);

        // reset asserted during WRITE
        master_enable = 1'b1;
        sram_ack      = 1'b0;
        start_sram    = 4'b0010;
        n = 0;
        while (!sram_we && n < 20) begin @(negedge wb_clk); n++; end
        chk("rmid_we_before", sram_we, 1'b1);
        #2;
        wb_rst_n = 1'b0;
        #1;
        chk("rmid_we", sram_we, 1'b0);
        chk("rmid_addr", sram_addr, 10'h0);
        chk("rmid_wdata", sram_wdata, 32'h0);
        chk("rmid_busy", busy, 1'b0);
        chk("rmid_grant", grant, 4'b0);
        chk("rmid_wrapped", wrapped, 4'b0);
        start_sram = 4'b0;
        sram_ack   = 1'b1;
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        gcount = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge wb_clk);
            if (sram_we || data_done != 4'b0 || grant != 4'b0) gcount++;
        end
        chk("rmid_no_pulse", gcount, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
